// File: rtl/dpwm_generator.sv
// -----------------------------------------------------------------------------
// dpwm_generator
//   DPWM output stage fed by the frequency memory. A prescaler divides CLK
//   into timebase ticks. A tick counter then walks through one PWM period of
//   'frecuencia' ticks. The period and compare values live in shadow registers
//   that are reloaded only at a period wrap or when the block is enabled, so a
//   period already in progress is never cut short or stretched by new inputs.
//
// Parameters
//   PRESC_DIV  CLK cycles per timebase tick
//   PRESC_W    prescaler width, must hold PRESC_DIV-1
//
// Ports
//   CLK         in   system clock
//   RST         in   asynchronous, active-high reset
//   enable      in   1 = generate PWM, 0 = idle with output low
//   frecuencia  in   [7:0] period in ticks (values below 2 are clamped to 2)
//   duty        in   [3:0] duty level n, high time = n/16 of the period
//   pwm_out     out  registered PWM waveform
//   period_end  out  one-CLK pulse marking the end of each completed period
//   running     out  high while the FSM is in RUN
// -----------------------------------------------------------------------------
module dpwm_generator #(
  parameter int PRESC_DIV = 100,
  parameter int PRESC_W   = 7
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       enable,
  input  logic [7:0] frecuencia,
  input  logic [3:0] duty,
  output logic       pwm_out,
  output logic       period_end,
  output logic       running
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nx;
  logic [PRESC_W-1:0] presc;
  logic [7:0]         cnt;
  logic [7:0]         per_sh;
  logic [7:0]         cmp_sh;

  logic [7:0]  per;
  logic [11:0] prod;
  logic [7:0]  cmp;
  logic        tick;
  logic        wrap;
  logic        pwm_d;
  logic        pe_d;
  logic        run_d;

  // Period clamp and compare value, computed from the live inputs. They only
  // reach the waveform through the shadow registers.
  assign per  = (frecuencia < 8'd2) ? 8'd2 : frecuencia;
  assign prod = {4'd0, per} * {8'd0, duty};
  assign cmp  = prod[11:4];

  assign tick = (presc == PRESC_W'(PRESC_DIV - 1));
  assign wrap = tick && (cnt == per_sh - 8'd1);

  // State register
  // NOTE: every clocked process uses non-blocking assignments so all flops
  // sample the pre-edge values, independent of process evaluation order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  // NOTE: each combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable)  state_nx = RUN;
      RUN:     if (!enable) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic. Dropping enable takes priority over a wrap that happens on
  // the same edge, so an abort never produces period_end. pwm_out is forced
  // low on the abort edge itself.
  always_comb begin
    pwm_d = 1'b0;
    pe_d  = 1'b0;
    run_d = (state_nx == RUN);
    if (state == RUN && enable) begin
      pwm_d = (cnt < cmp_sh);
      pe_d  = wrap;
    end
  end

  // Datapath: prescaler, tick counter, shadows and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc      <= '0;
      cnt        <= '0;
      per_sh     <= '0;
      cmp_sh     <= '0;
      pwm_out    <= 1'b0;
      period_end <= 1'b0;
      running    <= 1'b0;
    end else begin
      pwm_out    <= pwm_d;
      period_end <= pe_d;
      running    <= run_d;

      if (state == IDLE) begin
        presc <= '0;
        cnt   <= '0;
        if (enable) begin
          per_sh <= per;
          cmp_sh <= cmp;
        end
      end else if (!enable) begin
        // Abort: leave the counters clean for the next IDLE->RUN start.
        presc <= '0;
        cnt   <= '0;
      end else begin
        presc <= tick ? '0 : presc + PRESC_W'(1);
        if (wrap) begin
          cnt    <= '0;
          per_sh <= per;
          cmp_sh <= cmp;
        end else if (tick) begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dpwm_generator.sv
// -----------------------------------------------------------------------------
// tb_dpwm_generator
//   Self-checking bench for dpwm_generator with PRESC_DIV=4. The reference
//   model tracks the position inside the current period in CLK cycles. It
//   derives the expected outputs from that position with plain arithmetic:
//   a period lasts per*4 CLK, and the high phase covers the first cmp ticks.
//   Directed phases pin the model to hand-computed period and high-time
//   lengths. A randomized phase then exercises input changes and enable
//   toggling.
// -----------------------------------------------------------------------------
module tb_dpwm_generator;

  localparam int DIV = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] frecuencia = 8'd30;
  logic [3:0] duty = 4'd8;
  logic       pwm_out;
  logic       period_end;
  logic       running;

  int checks = 0;
  int errors = 0;

  dpwm_generator #(.PRESC_DIV(DIV), .PRESC_W(2)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .enable     (enable),
    .frecuencia (frecuencia),
    .duty       (duty),
    .pwm_out    (pwm_out),
    .period_end (period_end),
    .running    (running)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit m_run;
  int m_pos;   // CLK cycles elapsed in the current period
  int m_per;   // period in ticks
  int m_cmp;   // high ticks
  bit e_pwm, e_pe;

  function automatic int clamp_per(input int f);
    return (f < 2) ? 2 : f;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_run <= 1'b0; m_pos <= 0; m_per <= 0; m_cmp <= 0;
      e_pwm <= 1'b0; e_pe <= 1'b0;
    end else if (!m_run) begin
      e_pwm <= 1'b0;
      e_pe  <= 1'b0;
      if (enable) begin
        m_run <= 1'b1;
        m_pos <= 0;
        m_per <= clamp_per(int'(frecuencia));
        m_cmp <= clamp_per(int'(frecuencia)) * int'(duty) / 16;
      end
    end else if (!enable) begin
      m_run <= 1'b0;
      e_pwm <= 1'b0;
      e_pe  <= 1'b0;
    end else begin
      // The output reflects the tick index before this edge.
      e_pwm <= (m_pos / DIV) < m_cmp;
      if (m_pos + 1 == m_per * DIV) begin
        m_pos <= 0;
        m_per <= clamp_per(int'(frecuencia));
        m_cmp <= clamp_per(int'(frecuencia)) * int'(duty) / 16;
        e_pe  <= 1'b1;
      end else begin
        m_pos <= m_pos + 1;
        e_pe  <= 1'b0;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge CLK) begin
    check("pwm_out vs model", {31'd0, pwm_out}, {31'd0, e_pwm});
    check("period_end vs model", {31'd0, period_end}, {31'd0, e_pe});
    check("running vs model", {31'd0, running}, {31'd0, m_run});
  end

  // Counts CLK cycles (and pwm_out high cycles) up to and including the next
  // period_end pulse.
  task automatic wait_pe(output int len, output int hi);
    len = 0;
    hi  = 0;
    do begin
      @(negedge CLK);
      len++;
      if (pwm_out) hi++;
    end while (!period_end && len < 5000);
    if (len >= 5000) check("period_end timeout", {31'd0, period_end}, 32'd1);
  endtask

  task automatic measure(input string name, input int exp_len, input int exp_hi);
    int len, hi;
    wait_pe(len, hi);
    check({name, " period"}, len, exp_len);
    check({name, " high"}, hi, exp_hi);
  endtask

  initial begin
    int len, hi, n;
    RST = 1'b1;
    enable = 1'b1;
    frecuencia = 8'd30;
    duty = 4'd8;

    // Reset held 3 CLK with enable already high.
    repeat (3) begin
      @(negedge CLK);
      check("reset pwm_out", {31'd0, pwm_out}, 32'd0);
      check("reset period_end", {31'd0, period_end}, 32'd0);
      check("reset running", {31'd0, running}, 32'd0);
    end
    RST = 1'b0;
    @(negedge CLK);
    check("RUN after release", {31'd0, running}, 32'd1);

    // 30 ticks, duty 8: 60 high, 120 period.
    wait_pe(len, hi);
    measure("f30 d8", 120, 60);
    measure("f30 d8 again", 120, 60);

    // Period change mid-period: current period still 120, next 200.
    repeat (60) @(negedge CLK);
    frecuencia = 8'd50;
    wait_pe(len, hi);
    check("f30->50 current period", len + 60, 120);
    measure("f50 d8", 200, 100);

    // duty 0: never high, period_end still pulses.
    duty = 4'd0;
    wait_pe(len, hi);
    measure("f50 d0", 200, 0);

    // duty 15, 200 ticks: 187 ticks high.
    frecuencia = 8'd200;
    duty = 4'd15;
    wait_pe(len, hi);
    measure("f200 d15", 800, 748);

    // Period clamp.
    frecuencia = 8'd0;
    duty = 4'd8;
    wait_pe(len, hi);
    measure("f0 clamp", 8, 4);
    frecuencia = 8'd1;
    wait_pe(len, hi);
    measure("f1 clamp", 8, 4);

    // enable falling exactly on the wrap edge: IDLE wins, no period_end.
    frecuencia = 8'd30;
    wait_pe(len, hi);
    wait_pe(len, hi);
    repeat (119) @(negedge CLK);
    enable = 1'b0;
    @(negedge CLK);
    check("abort at wrap period_end", {31'd0, period_end}, 32'd0);
    check("abort at wrap running", {31'd0, running}, 32'd0);
    enable = 1'b1;
    @(negedge CLK);
    check("re-enable running", {31'd0, running}, 32'd1);
    measure("restart after wrap abort", 120, 60);

    // Mid-period abort, then restart from cnt=0.
    repeat (30) @(negedge CLK);
    enable = 1'b0;
    @(negedge CLK);
    check("mid abort pwm_out", {31'd0, pwm_out}, 32'd0);
    check("mid abort period_end", {31'd0, period_end}, 32'd0);
    repeat (5) @(negedge CLK);
    enable = 1'b1;
    @(negedge CLK);
    measure("restart after mid abort", 120, 60);

    // Async reset while pwm_out is high.
    n = 0;
    while (!pwm_out && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("pwm high before reset", {31'd0, pwm_out}, 32'd1);
    #1 RST = 1'b1;
    #1;
    check("async reset pwm_out", {31'd0, pwm_out}, 32'd0);
    check("async reset running", {31'd0, running}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Randomized phase, checked cycle by cycle against the model.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) frecuencia = 8'($urandom_range(0, 255));
      else                           frecuencia = 8'($urandom_range(0, 40));
      duty   = 4'($urandom_range(0, 15));
      enable = ($urandom_range(0, 9) != 0);
      repeat ($urandom_range(1, 150)) @(negedge CLK);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
